// File: rtl/mmio_console_pkg.sv
// Shared constants for the mmio_console register window: offsets, STATUS bit
// positions, bus widths and a byte-lane merge helper.
package mmio_console_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned BYTE_W = 8;

    typedef logic [ADDR_W-1:0] reg_off_t;

    localparam reg_off_t OFF_TXDATA = 2'd0;
    localparam reg_off_t OFF_STATUS = 2'd1;
    localparam reg_off_t OFF_CYCLE  = 2'd2;
    localparam reg_off_t OFF_EXIT   = 2'd3;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

    // Take enabled byte lanes from wdata, the rest from base.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [BE_W-1:0]   be,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] base
    );
        logic [DATA_W-1:0] merged;
        merged = base;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mmio_console_if.sv
// Word-addressed data bus between the core (master) and a memory-mapped
// responder (slave): select, offset, store data, lane enables, load request.
interface mmio_console_if;
    import mmio_console_pkg::*;

    logic              sel;
    reg_off_t          addr;
    logic [DATA_W-1:0] din;
    logic [BE_W-1:0]   bwe;
    logic              ren;
    logic [DATA_W-1:0] dout;

    modport master (output sel, addr, din, bwe, ren, input dout);
    modport slave  (input sel, addr, din, bwe, ren, output dout);

endinterface

// File: rtl/mmio_console_sync_fifo.sv
// Single-clock FIFO without fall-through; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_din,
    output logic [WIDTH-1:0]     o_dout,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_WIDTH'(DEPTH));
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_WIDTH'(1);
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console: TX byte FIFO, status, free-running cycle counter and
// sticky exit register behind a ram32-style bus with 1-cycle load latency.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    mmio_console_if.slave     bus,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              exit,
    output logic [DATA_W-1:0] exitcode
);

    logic [DATA_W-1:0]    r_dout;
    logic [DATA_W-1:0]    r_cycle;
    logic [DATA_W-1:0]    r_exitcode;
    logic                 r_exit;
    logic                 r_ovf;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_ovf_evt;
    logic                 w_ovf_clr;
    logic [CNT_WIDTH-1:0] w_count;
    logic [DATA_W-1:0]    w_cyc_inc;
    logic [DATA_W-1:0]    w_status;
    logic [DATA_W-1:0]    w_rdata;

    assign w_wr      = bus.sel && (bus.bwe != '0);
    assign w_rd      = bus.sel && bus.ren;
    assign w_push    = w_wr && (bus.addr == OFF_TXDATA) && bus.bwe[0];
    assign w_pop     = tx_valid && tx_ready;
    assign w_ovf_evt = w_push && w_full && !w_pop;
    assign w_ovf_clr = w_wr && (bus.addr == OFF_STATUS) && bus.bwe[0] && bus.din[ST_OVF];
    assign w_cyc_inc = r_cycle + 32'd1;

    sync_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (BYTE_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tx_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (bus.din[BYTE_W-1:0]),
        .o_dout  (tx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign tx_valid = !w_empty;
    assign exit     = r_exit;
    assign exitcode = r_exitcode;
    assign bus.dout = r_dout;

    always_comb begin
        w_status                                = '0;
        w_status[ST_EMPTY]                      = w_empty;
        w_status[ST_FULL]                       = w_full;
        w_status[ST_OVF]                        = r_ovf;
        w_status[ST_COUNT_LSB +: CNT_WIDTH]     = w_count;
    end

    // Load mux sees pre-edge state, so same-cycle stores return old values.
    always_comb begin
        w_rdata = '0;
        unique case (bus.addr)
            OFF_TXDATA: w_rdata = '0;
            OFF_STATUS: w_rdata = w_status;
            OFF_CYCLE:  w_rdata = r_cycle;
            OFF_EXIT:   w_rdata = r_exitcode;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout     <= '0;
            r_cycle    <= '0;
            r_exit     <= 1'b0;
            r_exitcode <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_rd) r_dout <= w_rdata;

            if (w_wr && (bus.addr == OFF_CYCLE)) r_cycle <= lane_merge(bus.bwe, bus.din, w_cyc_inc);
            else                                 r_cycle <= w_cyc_inc;

            // A new overflow takes priority over a same-cycle clear.
            if (w_ovf_evt)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;

            if (w_wr && (bus.addr == OFF_EXIT) && !r_exit) begin
                r_exit     <= 1'b1;
                r_exitcode <= lane_merge(bus.bwe, bus.din, '0);
            end
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: FIFO, STATUS, CYCLE wrap, EXIT and async reset.
module tb_mmio_console;
    import mmio_console_pkg::*;

    logic        clk;
    logic        resetn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        exit;
    logic [31:0] exitcode;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    mmio_console_if bus ();

    mmio_console #(.DEPTH(16), .CNT_WIDTH(5)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus.slave),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .exit     (exit),
        .exitcode (exitcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.sel  = 1'b0;
        bus.addr = 2'd0;
        bus.din  = 32'd0;
        bus.bwe  = 4'd0;
        bus.ren  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.sel = 1'b1; bus.addr = a; bus.din = d; bus.bwe = be; bus.ren = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.addr = a; bus.din = 32'd0; bus.bwe = 4'd0; bus.ren = 1'b1;
        tick();
        d = bus.dout;
        bus_idle();
    endtask

    initial begin
        resetn   = 1'b0;
        tx_ready = 1'b0;
        bus_idle();
        #2;
        check_eq("rst_dout",     bus.dout,          32'h0);
        check_eq("rst_tx_valid", 32'(tx_valid),     32'h0);
        check_eq("rst_tx_data",  32'(tx_data),      32'h0);
        check_eq("rst_exit",     32'(exit),         32'h0);
        check_eq("rst_exitcode", exitcode,          32'h0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        rd(OFF_STATUS, rdata);
        check_eq("status_after_reset", rdata, 32'h0000_0001);

        // Three bytes queued, then drained in order.
        wr(OFF_TXDATA, 32'h41, 4'b0001);
        check_eq("no_fallthrough_valid", 32'(tx_valid), 32'h1);
        wr(OFF_TXDATA, 32'h42, 4'b0001);
        wr(OFF_TXDATA, 32'h43, 4'b0001);
        rd(OFF_STATUS, rdata);
        check_eq("status_count3", rdata, 32'h0000_0300);
        check_eq("head_stable", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        tick();
        check_eq("pop_1", 32'(tx_data), 32'h42);
        tick();
        check_eq("pop_2", 32'(tx_data), 32'h43);
        tick();
        check_eq("drained_valid", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Overflow on the 17th byte, W1C clear, push-while-full-with-pop.
        for (int i = 0; i < 17; i++) wr(OFF_TXDATA, 32'(8'h60 + i), 4'b0001);
        rd(OFF_STATUS, rdata);
        check_eq("status_full_ovf", rdata, 32'h0000_1006);
        wr(OFF_STATUS, 32'h4, 4'b0001);
        rd(OFF_STATUS, rdata);
        check_eq("status_ovf_cleared", rdata, 32'h0000_1002);
        tx_ready = 1'b1;
        wr(OFF_TXDATA, 32'h99, 4'b0001);
        tx_ready = 1'b0;
        rd(OFF_STATUS, rdata);
        check_eq("full_push_pop", rdata, 32'h0000_1002);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_order", 32'(tx_data), (i < 15) ? 32'(8'h61 + i) : 32'h99);
            tick();
        end
        check_eq("drain_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Only lane 0 pushes.
        wr(OFF_TXDATA, 32'hFFFF_41FF, 4'b0010);
        check_eq("lane1_no_push", 32'(tx_valid), 32'h0);
        rd(OFF_STATUS, rdata);
        check_eq("lane1_status", rdata, 32'h0000_0001);

        // Cycle counter load, wrap and partial-lane write.
        wr(OFF_CYCLE, 32'hFFFF_FFFE, 4'b1111);
        tick();
        rd(OFF_CYCLE, rdata);
        check_eq("cycle_max", rdata, 32'hFFFF_FFFF);
        rd(OFF_CYCLE, rdata);
        check_eq("cycle_wrap", rdata, 32'h0000_0000);
        wr(OFF_CYCLE, 32'h0000_1000, 4'b1111);
        wr(OFF_CYCLE, 32'h00AB_0000, 4'b0100);
        rd(OFF_CYCLE, rdata);
        check_eq("cycle_lane_merge", rdata, 32'h00AB_1001);

        // Unselected store must not set exit.
        bus.sel = 1'b0; bus.addr = OFF_EXIT; bus.din = 32'h77; bus.bwe = 4'b1111;
        tick();
        bus_idle();
        check_eq("exit_unselected", 32'(exit), 32'h0);

        // Store and load to EXIT in one cycle: load sees old code.
        bus.sel = 1'b1; bus.addr = OFF_EXIT; bus.din = 32'h2A; bus.bwe = 4'b1111; bus.ren = 1'b1;
        tick();
        bus_idle();
        check_eq("exit_rw_old", bus.dout, 32'h0);
        check_eq("exit_set", 32'(exit), 32'h1);
        check_eq("exitcode_set", exitcode, 32'h2A);
        wr(OFF_EXIT, 32'h55, 4'b1111);
        check_eq("exitcode_sticky", exitcode, 32'h2A);
        rd(OFF_EXIT, rdata);
        check_eq("exit_read", rdata, 32'h2A);

        // Asynchronous reset with bytes queued.
        for (int i = 0; i < 5; i++) wr(OFF_TXDATA, 32'(8'h11 + i), 4'b0001);
        check_eq("pre_rst_valid", 32'(tx_valid), 32'h1);
        check_eq("pre_rst_head", 32'(tx_data), 32'h11);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(tx_valid), 32'h0);
        check_eq("async_rst_exit", 32'(exit), 32'h0);
        check_eq("async_rst_code", exitcode, 32'h0);
        check_eq("async_rst_dout", bus.dout, 32'h0);
        check_eq("async_rst_data", 32'(tx_data), 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        rd(OFF_STATUS, rdata);
        check_eq("status_after_rerst", rdata, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
